// File: rtl/dff_bank_pkg.sv
// Shared definitions for the shared-register arbiter:
// command op codes and arbiter FSM state codes.
package dff_bank_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bundle of the shared-register arbiter.
// master: requesters (req/lock/op/wdata out, gnt/Q/Q_bar/owner/locked in)
// slave : arbiter (the reverse directions)
interface dff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    import dff_bank_pkg::*;

    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      Q;
    logic [WIDTH-1:0]      Q_bar;
    logic [IDXW-1:0]       owner;
    logic                  locked;

    modport master (
        output req, lock, op, wdata,
        input  gnt, Q, Q_bar, owner, locked
    );

    modport slave (
        input  req, lock, op, wdata,
        output gnt, Q, Q_bar, owner, locked
    );

endinterface

// File: rtl/dff_bank_reg.sv
// Shared WIDTH-bit register with decoded one-cycle commands.
// Ports: clk, reset (sync, active-high), i_load/i_set/i_clear/i_toggle,
//        i_data (load value), o_q (contents), o_q_bar (inverse).
module dff_bank_reg
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_set,
    input  logic             i_clear,
    input  logic             i_toggle,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_bar
);

    logic [WIDTH-1:0] r_q;

    // At most one command is active per cycle; the
    // priority order only matters for illegal combos.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_set) begin
            r_q <= '1;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_toggle) begin
            r_q <= ~r_q;
        end
    end

    assign o_q     = r_q;
    assign o_q_bar = ~r_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one register among NREQ requesters.
// Ports: clk, reset (sync, active-high), bus (slave modport: req, lock,
//        op, wdata in; gnt, Q, Q_bar, owner, locked out).
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 8,
    localparam int IDXW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    dff_bank_arbiter_if.slave   bus
);

    state_t           r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW-1:0]  r_owner;
    logic             r_locked;

    logic [IDXW-1:0]  w_win;
    logic [IDXW-1:0]  w_sel;
    logic [NREQ-1:0]  w_gnt;
    logic             w_xfer;
    op_t              w_op;
    logic [WIDTH-1:0] w_data;
    logic             w_sel_lock;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;

    // Rotating priority in two passes: the lowest requester
    // overall is the wrap-around fallback, and the lowest
    // requester at or above ptr overrides it.
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_win = IDXW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i] && (IDXW'(i) >= r_ptr)) begin
                w_win = IDXW'(i);
            end
        end
    end

    // In ARB the selected requester is the winner (whose req is
    // high whenever any req is); in LOCKED it is the owner. So
    // grant is simply req of the selected index.
    always_comb begin
        w_sel      = (r_state == ST_ARB) ? w_win : r_owner;
        w_gnt      = '0;
        w_op       = OP_LOAD;
        w_data     = '0;
        w_sel_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDXW'(i) == w_sel) begin
                w_gnt[i]   = bus.req[i] && !reset;
                w_op       = op_t'(bus.op[2*i +: 2]);
                w_data     = bus.wdata[WIDTH*i +: WIDTH];
                w_sel_lock = bus.lock[i];
            end
        end
    end

    assign w_xfer = |w_gnt;

    dff_bank_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_xfer && (w_op == OP_LOAD)),
        .i_set    (w_xfer && (w_op == OP_SET)),
        .i_clear  (w_xfer && (w_op == OP_CLEAR)),
        .i_toggle (w_xfer && (w_op == OP_TOGGLE)),
        .i_data   (w_data),
        .o_q      (w_q),
        .o_q_bar  (w_q_bar)
    );

    // ptr is only moved on ARB grants, so after a lock it
    // still points just past the former owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ARB;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_locked <= 1'b0;
        end else begin
            unique case (r_state)
                ST_ARB: begin
                    if (w_xfer) begin
                        r_owner <= w_sel;
                        r_ptr   <= (w_sel == IDXW'(NREQ - 1)) ?
                                   '0 : w_sel + 1'b1;
                        if (w_sel_lock) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!w_sel_lock) begin
                        r_state  <= ST_ARB;
                        r_locked <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.gnt    = w_gnt;
    assign bus.Q      = w_q;
    assign bus.Q_bar  = w_q_bar;
    assign bus.owner  = r_owner;
    assign bus.locked = r_locked;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios with literal
// expectations, then constrained-random traffic vs a reference model.
module tb_dff_bank_arbiter;
    import dff_bank_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

    dff_bank_arbiter #(
        .NREQ  (N),
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [W-1:0] m_q;
    int           m_ptr;
    int           m_owner;
    bit           m_locked;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Index of the requester that transfers this cycle, or -1.
    function automatic int m_pick();
        if (reset) return -1;
        if (m_locked) return bus.req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (bus.req[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        int w;
        logic [N-1:0] g;
        w = m_pick();
        g = '0;
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    function automatic logic [W-1:0] m_qbar();
        return ~m_q;
    endfunction

    task automatic m_step();
        int w;
        logic [1:0] o;
        w = m_pick();
        if (reset) begin
            m_q      <= '0;
            m_ptr    <= 0;
            m_owner  <= 0;
            m_locked <= 1'b0;
        end else begin
            if (w >= 0) begin
                o = bus.op[2*w +: 2];
                case (o)
                    2'd0:    m_q <= bus.wdata[W*w +: W];
                    2'd1:    m_q <= '1;
                    2'd2:    m_q <= '0;
                    default: m_q <= ~m_q;
                endcase
            end
            if (!m_locked) begin
                if (w >= 0) begin
                    m_owner  <= w;
                    m_ptr    <= (w + 1) % N;
                    m_locked <= bus.lock[w];
                end
            end else if (!bus.lock[m_owner]) begin
                m_locked <= 1'b0;
            end
        end
    endtask

    always @(posedge clk) m_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt",    bus.gnt,    m_gnt());
            chk("Q",      bus.Q,      m_q);
            chk("Q_bar",  bus.Q_bar,  m_qbar());
            chk("owner",  bus.owner,  m_owner);
            chk("locked", bus.locked, m_locked);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic r, logic l,
                           logic [1:0] o, logic [W-1:0] d);
        bus.req[i]         = r;
        bus.lock[i]        = l;
        bus.op[2*i +: 2]   = o;
        bus.wdata[W*i +: W] = d;
    endtask

    task automatic clr_all();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, OP_LOAD, '0);
    endtask

    logic [N-1:0] g_prev;

    initial begin
        reset     = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.op    = '0;
        bus.wdata = '0;

        // Reset then idle
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        at_neg();
        chk("rst_Q",      bus.Q,      8'h00);
        chk("rst_Q_bar",  bus.Q_bar,  8'hFF);
        chk("rst_gnt",    bus.gnt,    4'b0000);
        chk("rst_owner",  bus.owner,  0);
        chk("rst_locked", bus.locked, 0);

        // Single LOAD from requester 2
        tick();
        set_req(2, 1'b1, 1'b0, OP_LOAD, 8'hA5);
        at_neg();
        chk("load_gnt", bus.gnt, 4'b0100);
        tick();
        set_req(2, 1'b0, 1'b0, OP_LOAD, 8'h00);
        at_neg();
        chk("load_Q",     bus.Q,     8'hA5);
        chk("load_owner", bus.owner, 2);

        // Round robin from ptr=0, SET/CLEAR alternating
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 1'b0, (i % 2) ? OP_CLEAR : OP_SET, '0);
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] eg;
            eg = '0;
            eg[k % N] = 1'b1;
            at_neg();
            chk("rr_gnt", bus.gnt, eg);
            chk("rr_Q",   bus.Q,   (k % 2) ? 8'hFF : 8'h00);
        end
        at_neg();
        chk("rr_Q_end", bus.Q, 8'hFF);
        tick();
        clr_all();

        // Lock with toggle while requester 1 waits
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(3, 1'b1, 1'b0, OP_LOAD, 8'h0F);
        at_neg();
        chk("lk_pre_gnt", bus.gnt, 4'b1000);
        tick();
        set_req(3, 1'b0, 1'b0, OP_LOAD, 8'h00);
        set_req(0, 1'b1, 1'b1, OP_TOGGLE, 8'h00);
        set_req(1, 1'b1, 1'b0, OP_SET, 8'h00);
        at_neg();
        chk("lk_gnt0", bus.gnt, 4'b0001);
        chk("lk_Q0",   bus.Q,   8'h0F);
        at_neg();
        chk("lk_gnt1", bus.gnt,    4'b0001);
        chk("lk_Q1",   bus.Q,      8'hF0);
        chk("lk_on",   bus.locked, 1);
        at_neg();
        chk("lk_gnt2", bus.gnt, 4'b0001);
        chk("lk_Q2",   bus.Q,   8'h0F);
        tick();
        set_req(0, 1'b0, 1'b0, OP_LOAD, 8'h00);
        at_neg();
        chk("lk_Q3",    bus.Q,      8'hF0);
        chk("lk_idle",  bus.gnt,    4'b0000);
        at_neg();
        chk("lk_off",   bus.locked, 0);
        chk("lk_next",  bus.gnt,    4'b0010);
        tick();
        set_req(1, 1'b0, 1'b0, OP_LOAD, 8'h00);
        at_neg();
        chk("lk_setQ", bus.Q, 8'hFF);

        // Wrap from ptr=NREQ-1 back to 0
        set_req(2, 1'b1, 1'b0, OP_LOAD, 8'h5A);
        at_neg();
        chk("wr_pre", bus.gnt, 4'b0100);
        tick();
        set_req(2, 1'b0, 1'b0, OP_LOAD, 8'h00);
        set_req(0, 1'b1, 1'b0, OP_CLEAR, 8'h00);
        set_req(1, 1'b1, 1'b0, OP_TOGGLE, 8'h00);
        at_neg();
        chk("wr_gnt0", bus.gnt, 4'b0001);
        at_neg();
        chk("wr_gnt1", bus.gnt, 4'b0010);
        chk("wr_Q",    bus.Q,   8'h00);
        tick();
        clr_all();

        // Reset in the middle of a lock
        set_req(0, 1'b1, 1'b1, OP_LOAD, 8'h3C);
        at_neg();
        chk("mr_pre", bus.gnt, 4'b0001);
        tick();
        set_req(0, 1'b1, 1'b1, OP_TOGGLE, 8'h00);
        set_req(1, 1'b1, 1'b0, OP_SET, 8'h00);
        at_neg();
        chk("mr_lock", bus.locked, 1);
        chk("mr_Q",    bus.Q,      8'h3C);
        chk("mr_gnt",  bus.gnt,    4'b0001);
        tick();
        reset = 1'b1;
        at_neg();
        chk("mr_gnt_rst", bus.gnt, 4'b0000);
        chk("mr_Q_tog",   bus.Q,   8'hC3);
        tick();
        at_neg();
        chk("mr_Q0",    bus.Q,      8'h00);
        chk("mr_unlk",  bus.locked, 0);
        chk("mr_own",   bus.owner,  0);
        chk("mr_gnt0",  bus.gnt,    4'b0000);
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, OP_SET, 8'h00);
        at_neg();
        chk("mr_ptr0", bus.gnt, 4'b0001);

        // Random traffic: a requester only changes its request
        // after being granted or while idle.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            g_prev = bus.gnt;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (g_prev[i] || !bus.req[i]) begin
                    set_req(i,
                            $urandom_range(0, 2) != 0,
                            $urandom_range(0, 5) == 0,
                            2'($urandom_range(0, 3)),
                            W'($urandom));
                end
            end
        end

        tick();
        reset = 1'b0;
        clr_all();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
Round-robin arbiter and sequencer that shares one WIDTH-bit flip-flop register between NREQ requesters. Each requester issues a command: load, set-all, clear-all or toggle. A grant performs one register update per clock. A requester may lock ownership for back-to-back private updates. Sits in front of the shared D-flip-flop register bank and is the only path that writes it.

Parameters:
NREQ, 4, number of requesters (2..8, need not be a power of two)
WIDTH, 8, register width in bits
IDXW, $clog2(NREQ), width of owner index (derived, not overridden)

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high; sampled on posedge clk
req  input  NREQ  per-requester request, held until granted
lock  input  NREQ  per-requester lock request, sampled with req
op  input  2*NREQ  per-requester command, op[2i+1:2i]
wdata  input  WIDTH*NREQ  per-requester load data, wdata[WIDTH*i +: WIDTH]
gnt  output  NREQ  one-hot grant (combinational), all zero when no transfer
Q  output  WIDTH  shared register contents
Q_bar  output  WIDTH  bitwise inverse of Q, continuous
owner  output  IDXW  index of the last granted requester
locked  output  1  high while in LOCKED state

Behaviour:
- Reset (reset=1 at posedge): Q=0, Q_bar=all ones, ptr=0, owner=0, state=ARB, locked=0. gnt forced to 0 while reset=1. Reset overrides every request, including mid-lock.
- Transfer rule: a transfer to requester i occurs at a posedge where gnt[i]=1. Requester drops or changes req/op/wdata only after a cycle with gnt[i]=1. Zero-latency handshake; Q shows the new value the cycle after the grant.
- Op encoding: 00 LOAD Q<=wdata slice; 01 SET Q<=all ones; 10 CLEAR Q<=0; 11 TOGGLE Q<=~Q. Without a transfer, Q holds.
- State ARB: the winner is the first i with req[i]=1, searching from ptr upward and wrapping NREQ-1 to 0. gnt[winner]=1. On the edge: apply op, owner<=winner, ptr<=(winner+1) mod NREQ. If lock[winner]=1, go to LOCKED; otherwise stay in ARB. No req means gnt=0 and ptr holds.
- State LOCKED: only owner is eligible, gnt[owner]=req[owner], and every other req is ignored (no starvation counter). Each edge with req[owner]=1 applies that op.
  - Exit to ARB at the first edge where lock[owner]=0. If req[owner]=1 at that edge, its final transfer still happens.
  - ptr stays at owner+1, so the next ARB round starts after the former owner.
- locked = (state==LOCKED), registered.
- Simultaneous requests: exactly one grant per cycle. Losers keep req high and are served in rotation order.
- Back-to-back: the same requester can win in consecutive ARB cycles only if no other requester is asserting.
- Out-of-range op values are impossible, since the 2-bit encoding is full.

Decomposition:
- Shared package dff_bank_pkg: op codes OP_LOAD=2'b00, OP_SET=2'b01, OP_CLEAR=2'b10, OP_TOGGLE=2'b11; state codes ST_ARB=1'b0, ST_LOCKED=1'b1.
- One sub-module, dff_bank_reg: WIDTH-bit register with sync reset, plus load/set/clear/toggle controls and Q_bar. It is driven by a decoded one-cycle command from the arbiter.
- Arbitration, pointer and FSM stay in the top.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then req=0 -> Q=8'h00, Q_bar=8'hFF, gnt=0, owner=0, locked=0.
- Single LOAD: req=4'b0100, op2=LOAD, wdata2=8'hA5 -> gnt=4'b0100 that cycle; next cycle Q=8'hA5, owner=2.
- Round-robin: req=4'b1111 held, all SET/CLEAR alternating, from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001; Q alternates FF/00.
- Lock: req0 with lock0=1, op TOGGLE, Q=8'h0F, req1 also high -> gnt=0001 for 3 cycles, Q=F0,0F,F0. Drop lock0 -> locked falls; next grant goes to 0010.
- Wrap with NREQ=3: ptr=2, req=3'b011 -> gnt=001, then gnt=010.
- Reset mid-lock: in LOCKED with Q=8'h3C, assert reset -> next cycle Q=0, locked=0, ptr=0, gnt=0 while reset high.
